// File: rtl/serial_bit_source_pkg.sv
// Shared definitions for the serial bit source: state encoding, idle line level, default word width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package serial_bit_source_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Level driven on x whenever no word is being shifted; keeps the detector in its start state.
  localparam logic IDLE_LEVEL = 1'b0;

  // PARITY is only reachable when SERIAL_BIT_SOURCE_PARITY_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    DONE   = 2'b10,
    PARITY = 2'b11
  } state_t;

  // Bit counter width; never below one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_bit_source_if.sv
// Word-in / bit-out bundle between a word producer (master) and the serial bit source (slave).
// Latency: n/a (wiring only).
// Backpressure: producer may only hand over a word while ready=1.
interface serial_bit_source_if
  import serial_bit_source_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             x;
  logic             busy;
  logic             done;

  modport master (
    output data_in,
    output load,
    input  ready,
    input  x,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  load,
    output ready,
    output x,
    output busy,
    output done
  );

endinterface

// File: rtl/serial_bit_counter.sv
// Loadable down-counter with a zero flag; tracks how many bits of the word remain.
// Latency: load/decrement visible one cycle after the enabling edge.
// Backpressure: none; decrement saturates at zero, load has priority.
module serial_bit_counter #(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_en,
  input  logic [CW-1:0] load_val,
  input  logic          dec_en,
  output logic          zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_en) begin
      cnt_d = load_val;
    end else if (dec_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial bit source: accepts a WIDTH-bit word and emits it one bit per clock on x,
// Latency: first bit on x the cycle after accept, done pulse WIDTH+1 cycles after accept
// (WIDTH+2 with SERIAL_BIT_SOURCE_PARITY_EN, which appends an even-parity bit).
// Backpressure: ready=0 from accept until the cycle after done; load while not ready is dropped.
module serial_bit_source
  import serial_bit_source_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_bit_source_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  logic             par_q, par_d;
`endif

  // Bit that leaves the word first, according to the bit order.
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Word with the head bit consumed, next bit moved into the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  serial_bit_counter #(
    .CW (CW)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load_en  (cnt_load),
    .load_val (CW'(WIDTH - 1)),
    .dec_en   (cnt_dec),
    .zero     (cnt_zero)
  );

  // FSM next state plus next values of the registered outputs. Outputs are computed one
  // cycle ahead so each one comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    x_d      = IDLE_LEVEL;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ready_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.load) begin
          // First bit goes straight to x; the register keeps the remaining bits.
          x_d      = head(bus.data_in);
          shift_d  = advance(bus.data_in);
          busy_d   = 1'b1;
          ready_d  = 1'b0;
          cnt_load = 1'b1;
          state_d  = SHIFT;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
          par_d    = ^bus.data_in;
`endif
        end
      end
      SHIFT: begin
        if (cnt_zero) begin
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
          x_d     = par_q;
          busy_d  = 1'b1;
          state_d = PARITY;
`else
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end else begin
          x_d     = head(shift_q);
          shift_d = advance(shift_q);
          busy_d  = 1'b1;
          cnt_dec = 1'b1;
        end
      end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
      PARITY: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
`endif
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        // Unreachable encoding: fall back to idle with the line low.
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, shift register and output flops; reset aborts any word in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      x_q     <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  // Parity of the captured word, held until the parity cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign bus.ready = ready_q;
  assign bus.x     = x_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Parallel-to-serial bit source feeding the 1-bit input `x` of the sequence-detector stage directly downstream.
- Accepts a WIDTH-bit word through a load/ready handshake and emits it one bit per clock on `x`.
- Reports `busy` while shifting and pulses `done` after the last bit.
- Drives `x` low whenever idle, so the downstream detector is held in its start state between words.

Parameters:
- WIDTH, 8, number of data bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first.

Ports:
- clock, input, 1, single system clock; all state updates on posedge.
- reset, input, 1, asynchronous active-low reset; 0 forces reset state immediately.
- data_in, input, WIDTH, word to serialize; sampled only on an accepted load.
- load, input, 1, load request; accepted at a posedge when load=1 and ready=1.
- ready, output, 1, 1 when a new word can be accepted.
- x, output, 1, serial bit stream to the detector; 0 when not shifting.
- busy, output, 1, 1 while data (or parity) bits are being presented on x.
- done, output, 1, one-cycle pulse after the final bit of a word.

Behaviour:
- All outputs are registered (Moore); no combinational path from load or data_in to any output.
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - ready=1, x=0, busy=0, done=0.
  - Reset asserted mid-word aborts the word immediately; no done pulse is produced.
- States: IDLE, SHIFT, DONE. Two-bit encoding, defined in the package.
- IDLE:
  - ready=1, busy=0, x=0, done=0.
  - load=1 at posedge t: capture data_in into the shift register, counter=WIDTH-1, go to SHIFT.
  - load=0: stay in IDLE.
- SHIFT:
  - ready=0, busy=1, x=current bit (MSB or LSB of the shift register per MSB_FIRST).
  - Each posedge shifts the register and decrements the counter.
  - Word timing: bit k appears on x during cycle t+1+k, for k=0..WIDTH-1.
  - Counter=0 at posedge: go to DONE.
- DONE (cycle t+WIDTH+1): done=1, x=0, busy=0, ready=0. Next posedge: go to IDLE.
- load while ready=0 is ignored; data_in is not sampled and there is no queueing.
- Back-to-back words: earliest next accept is the posedge ending cycle t+WIDTH+2. Throughput is one word per WIDTH+2 cycles.
- Illegal state encoding: return to IDLE on the next posedge with x=0.
- done and busy are never high in the same cycle.

Optional Feature:
- Macro: SERIAL_BIT_SOURCE_PARITY_EN.
- Defined:
  - Adds state PARITY between SHIFT and DONE.
  - x = even-parity bit (XOR of all WIDTH captured bits) for one cycle, with busy=1.
  - done shifts to cycle t+WIDTH+2; word period becomes WIDTH+3.
- Undefined: no PARITY state and no parity logic; timing exactly as in Behaviour.

Decomposition:
- Shared package:
  - State encoding constants IDLE/SHIFT/DONE/PARITY.
  - Idle-line level constant (0).
  - Default WIDTH.
- One natural sub-module: serial_bit_counter.
  - Loadable down-counter of width clog2(WIDTH) with a zero flag.
  - Same clock/reset convention.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with load=1 -> ready=1, x=0, busy=0, done=0; no word accepted; release -> word accepted at the first posedge with load=1.
- MSB_FIRST=1, WIDTH=8, load 8'b11010000 at t:
  - x = 1,1,0,1,0,0,0,0 in cycles t+1..t+8, busy=1 throughout.
  - done=1 only in t+9; ready=1 again at t+10.
  - Downstream detector y=1 exactly once, in cycle t+4.
- MSB_FIRST=0, load 8'hA5 -> x = 1,0,1,0,0,1,0,1; done at t+9.
- load held high continuously with words 8'hFF then 8'h0D -> second word accepted only when ready=1 at t+10; load pulses while ready=0 have no effect on x.
- reset pulled low during cycle t+4 of a word -> x=0 and busy=0 asynchronously; no done pulse; next load starts a clean word.
- With SERIAL_BIT_SOURCE_PARITY_EN defined, load 8'b10110000 -> parity bit 1 on x at t+9 with busy=1; done=1 at t+10; repeat with 8'b10010000 -> parity bit 0.
